mult_seq_ctrl: RTL
==================

// Module: mult_seq_ctrl
// PURPOSE
//   Sequences one external combinational 4x4 unsigned multiplier core (8-bit product) to form an OP_W x OP_W unsigned product.
//   Operands are taken as 4-bit digits; one digit product per cycle is shifted and accumulated.
//   Sits between a valid/ready requester and the multiplier core; the core is instantiated outside this block.
// PARAMETERS
//   OP_W    8   operand width in bits; must be a multiple of 4 and >= 4 (N = OP_W/4 digits)
//   CNT_W   4   width of the digit-step counter; must satisfy 2**CNT_W >= N*N
// PORTS
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous active-low reset
//   in_valid  in   1        operand pair valid
//   in_ready  out  1        block can accept an operand pair
//   in_a      in   OP_W     multiplicand, unsigned
//   in_b      in   OP_W     multiplier, unsigned
//   out_valid out  1        product valid
//   out_ready in   1        consumer accepts product
//   out_p     out  2*OP_W   product in_a*in_b, unsigned
//   core_x    out  4        digit to core operand x
//   core_y    out  4        digit to core operand y
//   core_o    in   8        core product core_x*core_y, combinational, same cycle
//   busy      out  1        1 in CALC or DONE
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE; in_ready=0; out_valid=0; out_p=0; busy=0; accumulator=0; step counter k=0.
//   in_ready is a flop: 0 in reset, 1 from the first clk edge after rst_n rises while state=IDLE.
//   FSM, three states:
//   - IDLE: in_ready=1. On in_valid&in_ready: latch in_a/in_b, clear acc, k=0, in_ready->0, go CALC. Else stay.
//   - CALC: i = k mod N (a digit), j = k div N (b digit).
//     core_x=a_q[4i+3:4i], core_y=b_q[4j+3:4j].
//     Each edge: acc <= acc + (core_o << 4*(i+j)), computed in 2*OP_W bits; cannot overflow.
//     Then k++. On the edge where k=N*N-1: load out_p with the final sum, out_valid->1, go DONE.
//   - DONE: out_valid=1; out_p held stable. On out_valid&out_ready: out_valid->0, in_ready->1, go IDLE.
//   Outside CALC: core_x=core_y=0.
//   Latency: accept edge, then N*N CALC edges. out_valid rises N*N edges after accept (4 for OP_W=8, 16 for OP_W=16).
//   Throughput: one product per N*N+2 cycles minimum (accept and pop edges not overlapped).
//   in_valid while in_ready=0: ignored, no side effect. in_a/in_b changes after the accept edge: no effect.
//   out_ready while out_valid=0: ignored. Backpressure in DONE: hold indefinitely, out_p unchanged.
//   Mid-operation reset (CALC or DONE): all state returns to reset values immediately. The in-flight product is discarded, never emitted.
//   Handshake: out_valid never drops without out_ready; out_p changes only while out_valid=0.
// TESTING
//   1 OP_W=8: in_a=8'h12, in_b=8'h34, out_ready=1 -> out_valid 4 edges after accept, out_p=16'h03A8, core_x/core_y sequence (2,4),(1,4),(2,3),(1,3).
//   2 OP_W=8: in_a=in_b=8'hFF -> out_p=16'hFE01. Also 8'h00*8'hA5 -> 16'h0000. Also 8'h01*8'hFF -> 16'h00FF.
//   3 Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and in_a/in_b toggling -> out_p stable, in_ready=0, no new accept; release -> one pop, in_ready=1 next cycle.
//   4 Reset mid-CALC (after 2 steps): pulse rst_n low -> out_valid=0, in_ready=0, core_x=core_y=0 at once; in_ready=1 one edge after release; next op 8'h0F*8'h0F -> 16'h00E1.
//   5 OP_W=16: 16'hFFFF*16'hFFFF -> 32'hFFFE0001 after 16 CALC edges; 16'h1234*16'h5678 -> 32'h06260060.
//   6 Random back-to-back (>=10k ops, random in_valid/out_ready gaps) vs reference model a*b. Every accepted op emitted exactly once, in order.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequencer that drives an external 4x4 multiplier core one digit pair per cycle and
// shift-accumulates the digit products into an OP_W x OP_W unsigned product.
module mult_seq_ctrl #(
  parameter int unsigned OP_W  = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] out_p,
  output logic [3:0]        core_x,
  output logic [3:0]        core_y,
  input  logic [7:0]        core_o,
  output logic              busy
);

  localparam int unsigned N   = OP_W / 4;
  localparam int unsigned P_W = 2 * OP_W;
  localparam logic [CNT_W-1:0] KLast = CNT_W'(N * N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [P_W-1:0]   out_p_q, out_p_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [OP_W-1:0]  a_q, a_d;
  logic [OP_W-1:0]  b_q, b_d;

  int unsigned      dig_i, dig_j;
  logic [3:0]       dig_x, dig_y;
  logic [P_W-1:0]   partial, acc_sum;

  // k walks a's digits fastest: i = k mod N, j = k div N.
  always_comb begin
    dig_i   = 32'(k_q) % N;
    dig_j   = 32'(k_q) / N;
    dig_x   = 4'(a_q >> (4 * dig_i));
    dig_y   = 4'(b_q >> (4 * dig_j));
    partial = P_W'(core_o) << (4 * (dig_i + dig_j));
    acc_sum = acc_q + partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    acc_d       = acc_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = in_a;
          b_d        = in_b;
          acc_d      = '0;
          k_d        = '0;
          in_ready_d = 1'b0;
          state_d    = StCalc;
        end
      end
      StCalc: begin
        acc_d = acc_sum;
        k_d   = k_q + CNT_W'(1);
        if (k_q == KLast) begin
          out_p_d     = acc_sum;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    out_p     = out_p_q;
    busy      = (state_q != StIdle);
    core_x    = 4'd0;
    core_y    = 4'd0;
    if (state_q == StCalc) begin
      core_x = dig_x;
      core_y = dig_y;
    end
  end

endmodule
